// File: rtl/integral_image_generator.sv
// Raster 8-bit pixels in, integral image II(col,row) out. Defining INTEGRAL_SQUARED_EN adds the squared-integral path.
// Latency: 1 cycle from accept to strobe. Backpressure: pixel_ready is low only in the one-cycle DONE state; the output has none.
module integral_image_generator #(
   parameter int DATA_WIDTH_8      = 8,
   parameter int FRAME_WIDTH       = 320,
   parameter int FRAME_HEIGHT      = 240,
   parameter int INTEGRAL_WIDTH    = 25,
   parameter int SQ_INTEGRAL_WIDTH = 33,
   localparam int COL_W = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1,
   localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1
) (
   input  logic                         clk_fpga,
   input  logic                         reset_fpga,
   input  logic                         pixel_valid,
   output logic                         pixel_ready,
   input  logic [DATA_WIDTH_8-1:0]      pixel,
   input  logic                         frame_start,
   output logic                         integral_valid,
   output logic [INTEGRAL_WIDTH-1:0]    integral,
   output logic [SQ_INTEGRAL_WIDTH-1:0] sq_integral,
   output logic [COL_W-1:0]             out_col,
   output logic [ROW_W-1:0]             out_row,
   output logic                         frame_done
);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);

   state_t                    state_q, state_d;
   logic [COL_W-1:0]          col_q;
   logic [ROW_W-1:0]          row_q;
   logic [INTEGRAL_WIDTH-1:0] row_sum_q;
   logic [INTEGRAL_WIDTH-1:0] linebuf [FRAME_WIDTH];

   logic                      accept;
   logic                      restart;
   logic                      last_pix;
   logic [COL_W-1:0]          cur_col, nxt_col;
   logic [ROW_W-1:0]          cur_row, nxt_row;
   logic [INTEGRAL_WIDTH-1:0] rs, above, ii;

   assign pixel_ready = (state_q != DONE);
   assign accept      = pixel_valid && pixel_ready;

   // IDLE always starts at (0,0); frame_start in STREAM abandons the partial frame.
   assign restart  = (state_q == IDLE) || ((state_q == STREAM) && frame_start);
   assign cur_col  = restart ? '0 : col_q;
   assign cur_row  = restart ? '0 : row_q;
   assign last_pix = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

   assign rs    = ((cur_col == '0) ? '0 : row_sum_q) + INTEGRAL_WIDTH'(pixel);
   assign above = (cur_row == '0) ? '0 : linebuf[cur_col];
   assign ii    = rs + above;

   always_comb begin
      nxt_col = cur_col + COL_W'(1);
      nxt_row = cur_row;
      if (cur_col == COL_LAST) begin
         nxt_col = '0;
         nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = last_pix ? DONE : STREAM;
         STREAM:  if (accept && last_pix) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_fpga or negedge reset_fpga) begin
      if (!reset_fpga) begin
         state_q        <= IDLE;
         col_q          <= '0;
         row_q          <= '0;
         row_sum_q      <= '0;
         integral_valid <= 1'b0;
         frame_done     <= 1'b0;
         integral       <= '0;
         out_col        <= '0;
         out_row        <= '0;
      end else begin
         state_q        <= state_d;
         integral_valid <= accept;
         frame_done     <= accept && last_pix;
         if (accept) begin
            col_q     <= nxt_col;
            row_q     <= nxt_row;
            row_sum_q <= rs;
            integral  <= ii;
            out_col   <= cur_col;
            out_row   <= cur_row;
         end
      end
   end

   // Line buffer holds the previous row's II; row 0 never reads it, so no reset.
   always_ff @(posedge clk_fpga) begin
      if (accept) linebuf[cur_col] <= ii;
   end

`ifdef INTEGRAL_SQUARED_EN
   logic [2*DATA_WIDTH_8-1:0]    pix_sq;
   logic [SQ_INTEGRAL_WIDTH-1:0] sq_row_sum_q;
   logic [SQ_INTEGRAL_WIDTH-1:0] sq_rs, sq_above, sq_ii;
   logic [SQ_INTEGRAL_WIDTH-1:0] sq_linebuf [FRAME_WIDTH];

   assign pix_sq   = {{DATA_WIDTH_8{1'b0}}, pixel} * {{DATA_WIDTH_8{1'b0}}, pixel};
   assign sq_rs    = ((cur_col == '0) ? '0 : sq_row_sum_q) + SQ_INTEGRAL_WIDTH'(pix_sq);
   assign sq_above = (cur_row == '0) ? '0 : sq_linebuf[cur_col];
   assign sq_ii    = sq_rs + sq_above;

   always_ff @(posedge clk_fpga or negedge reset_fpga) begin
      if (!reset_fpga) begin
         sq_row_sum_q <= '0;
         sq_integral  <= '0;
      end else if (accept) begin
         sq_row_sum_q <= sq_rs;
         sq_integral  <= sq_ii;
      end
   end

   always_ff @(posedge clk_fpga) begin
      if (accept) sq_linebuf[cur_col] <= sq_ii;
   end
`else
   assign sq_integral = '0;
`endif

endmodule

// File: tb/tb_integral_image_generator.sv
// Scoreboarded bench: a 4x3 instance for the directed cases and a 320x240 instance for the full-frame ramp.
module tb_integral_image_generator;

   localparam int SW = 4, SH = 3, LW = 320, LH = 240, IW = 25, SQW = 33;

   logic clk_fpga = 1'b0;
   logic reset_fpga = 1'b0;
   always #5 clk_fpga = ~clk_fpga;

   logic           s_pv = 1'b0, s_fs = 1'b0;
   logic [7:0]     s_px = '0;
   logic           s_rdy, s_iv, s_fd;
   logic [IW-1:0]  s_ii;
   logic [SQW-1:0] s_sq;
   logic [1:0]     s_col, s_row;

   logic           l_pv = 1'b0, l_fs = 1'b0;
   logic [7:0]     l_px = '0;
   logic           l_rdy, l_iv, l_fd;
   logic [IW-1:0]  l_ii;
   logic [SQW-1:0] l_sq;
   logic [8:0]     l_col;
   logic [7:0]     l_row;

   integral_image_generator #(
      .DATA_WIDTH_8(8), .FRAME_WIDTH(SW), .FRAME_HEIGHT(SH),
      .INTEGRAL_WIDTH(IW), .SQ_INTEGRAL_WIDTH(SQW)
   ) dut_s (
      .clk_fpga(clk_fpga), .reset_fpga(reset_fpga),
      .pixel_valid(s_pv), .pixel_ready(s_rdy), .pixel(s_px), .frame_start(s_fs),
      .integral_valid(s_iv), .integral(s_ii), .sq_integral(s_sq),
      .out_col(s_col), .out_row(s_row), .frame_done(s_fd)
   );

   integral_image_generator #(
      .DATA_WIDTH_8(8), .FRAME_WIDTH(LW), .FRAME_HEIGHT(LH),
      .INTEGRAL_WIDTH(IW), .SQ_INTEGRAL_WIDTH(SQW)
   ) dut_l (
      .clk_fpga(clk_fpga), .reset_fpga(reset_fpga),
      .pixel_valid(l_pv), .pixel_ready(l_rdy), .pixel(l_px), .frame_start(l_fs),
      .integral_valid(l_iv), .integral(l_ii), .sq_integral(l_sq),
      .out_col(l_col), .out_row(l_row), .frame_done(l_fd)
   );

   typedef struct {
      longint ii;
      longint sq;
      int     col;
      int     row;
      bit     fd;
   } exp_t;

   exp_t   q_s[$], q_l[$];
   longint got_s[$];
   longint last_l = 0;
   int     fd_cnt_s = 0;
   int     vectors = 0, miscompares = 0;

   // Reference built by inclusion-exclusion over a full-frame table.
   longint mii [LH][LW];
   longint msq [LH][LW];
   int     m_col = 0, m_row = 0;

   int t1_seq [12] = '{1, 2, 3, 4, 2, 4, 6, 8, 3, 6, 9, 12};

   function automatic void chk_val(input string nm, input longint got, input longint exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endfunction

   function automatic void chk_out(input string nm, input longint ii, input longint sq,
                                   input int col, input int row, input bit fd, input exp_t x);
      vectors++;
      if (ii != x.ii || sq != x.sq || col != x.col || row != x.row || fd != x.fd) begin
         miscompares++;
         $display("FAIL %s: got ii=%0d sq=%0d col=%0d row=%0d fd=%0b, expected ii=%0d sq=%0d col=%0d row=%0d fd=%0b",
                  nm, ii, sq, col, row, fd, x.ii, x.sq, x.col, x.row, x.fd);
      end
   endfunction

   function automatic longint got_at(input int i);
      if (i < got_s.size()) return got_s[i];
      return -1;
   endfunction

   task automatic send(input bit big, input int pix, input bit fs, input int gap);
      int     w, h, tries;
      longint e, s;
      exp_t   x;
      w = big ? LW : SW;
      h = big ? LH : SH;
      repeat (gap) begin
         @(negedge clk_fpga);
         if (big) begin l_pv = 1'b0; l_fs = 1'b0; end
         else     begin s_pv = 1'b0; s_fs = 1'b0; end
      end
      tries = 0;
      @(negedge clk_fpga);
      while (!(big ? l_rdy : s_rdy)) begin
         if (big) l_pv = 1'b0; else s_pv = 1'b0;
         tries++;
         if (tries > 8) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: pixel_ready stayed 0 for %0d cycles, expected 1", tries);
            return;
         end
         @(negedge clk_fpga);
      end
      if (fs) begin m_col = 0; m_row = 0; end
      e = pix;
      s = longint'(pix) * pix;
      if (m_col > 0) begin e += mii[m_row][m_col-1]; s += msq[m_row][m_col-1]; end
      if (m_row > 0) begin e += mii[m_row-1][m_col]; s += msq[m_row-1][m_col]; end
      if (m_col > 0 && m_row > 0) begin e -= mii[m_row-1][m_col-1]; s -= msq[m_row-1][m_col-1]; end
      mii[m_row][m_col] = e;
      msq[m_row][m_col] = s;
      x.ii  = e;
`ifdef INTEGRAL_SQUARED_EN
      x.sq  = s;
`else
      x.sq  = 0;
`endif
      x.col = m_col;
      x.row = m_row;
      x.fd  = (m_col == w - 1) && (m_row == h - 1);
      if (big) begin l_pv = 1'b1; l_px = 8'(pix); l_fs = fs; q_l.push_back(x); end
      else     begin s_pv = 1'b1; s_px = 8'(pix); s_fs = fs; q_s.push_back(x); end
      m_col++;
      if (m_col == w) begin
         m_col = 0;
         m_row = (m_row == h - 1) ? 0 : m_row + 1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk_fpga);
      s_pv = 1'b0; s_fs = 1'b0; l_pv = 1'b0; l_fs = 1'b0;
      while ((q_s.size() != 0 || q_l.size() != 0) && n < 20) begin
         @(negedge clk_fpga);
         n++;
      end
      if (n >= 20) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d/%0d results still outstanding, expected 0", q_s.size(), q_l.size());
         q_s.delete();
         q_l.delete();
      end
      repeat (2) @(negedge clk_fpga);
   endtask

   initial forever begin
      exp_t x;
      @(negedge clk_fpga);
      if (reset_fpga) begin
         if (s_iv) begin
            got_s.push_back(longint'(s_ii));
            if (q_s.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL s_unexpected_strobe: got ii=%0d col=%0d row=%0d, expected no strobe", s_ii, s_col, s_row);
            end else begin
               x = q_s.pop_front();
               chk_out("s_result", longint'(s_ii), longint'(s_sq), int'(s_col), int'(s_row), s_fd, x);
            end
         end
         if (s_fd) fd_cnt_s++;
         if (s_fd || !s_rdy) chk_val("s_ready_vs_done", longint'(s_rdy), longint'(!s_fd));
      end
   end

   initial forever begin
      exp_t x;
      @(negedge clk_fpga);
      if (reset_fpga) begin
         if (l_iv) begin
            last_l = longint'(l_ii);
            if (q_l.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL l_unexpected_strobe: got ii=%0d col=%0d row=%0d, expected no strobe", l_ii, l_col, l_row);
            end else begin
               x = q_l.pop_front();
               chk_out("l_result", longint'(l_ii), longint'(l_sq), int'(l_col), int'(l_row), l_fd, x);
            end
         end
         if (l_fd || !l_rdy) chk_val("l_ready_vs_done", longint'(l_rdy), longint'(!l_fd));
      end
   end

   initial begin
      #2000000;
      miscompares++;
      $display("FAIL watchdog: simulation still running at time limit, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk_fpga);
      chk_val("rst_ready_s", longint'(s_rdy), 1);
      chk_val("rst_valid_s", longint'(s_iv), 0);
      chk_val("rst_ii_s",    longint'(s_ii), 0);
      chk_val("rst_done_l",  longint'(l_fd), 0);
      chk_val("rst_ready_l", longint'(l_rdy), 1);
      reset_fpga = 1'b1;
      @(negedge clk_fpga);

      // All ones, continuous valid.
      got_s.delete(); fd_cnt_s = 0;
      for (int i = 0; i < 12; i++) send(1'b0, 1, 1'b0, 0);
      drain();
      chk_val("t1_count", got_s.size(), 12);
      for (int i = 0; i < 12; i++) chk_val($sformatf("t1_ii_%0d", i), got_at(i), t1_seq[i]);
      chk_val("t1_frame_done", fd_cnt_s, 1);

      // 0..11 ramp; frame_start on the first pixel while IDLE.
      got_s.delete();
      for (int i = 0; i < 12; i++) send(1'b0, i, i == 0, 0);
      drain();
      chk_val("t2_ii_3_0", got_at(3), 6);
      chk_val("t2_ii_3_1", got_at(7), 28);
      chk_val("t2_ii_3_2", got_at(11), 66);

      // Full 320x240 frame of a wrapping 0..255 ramp: 300 full cycles of 32640.
      for (int k = 0; k < LW * LH; k++) send(1'b1, k % 256, 1'b0, 0);
      drain();
      chk_val("t3_final_ii", last_l, 9792000);

      // All 255 with random gaps.
      got_s.delete();
      for (int i = 0; i < 12; i++) send(1'b0, 255, 1'b0, int'($urandom_range(5, 0)));
      drain();
      chk_val("t4_count", got_s.size(), 12);
      for (int i = 0; i < 12; i++) chk_val($sformatf("t4_ii_%0d", i), got_at(i), 255 * t1_seq[i]);
      chk_val("t4_final_ii", got_at(11), 3060);

      // Reset mid-frame after six pixels.
      for (int i = 0; i < 6; i++) send(1'b0, 1, 1'b0, 0);
      drain();
      @(negedge clk_fpga);
      reset_fpga = 1'b0;
      #1;
      chk_val("t5_rst_valid", longint'(s_iv), 0);
      chk_val("t5_rst_ii",    longint'(s_ii), 0);
      chk_val("t5_rst_col",   longint'(s_col), 0);
      chk_val("t5_rst_row",   longint'(s_row), 0);
      chk_val("t5_rst_done",  longint'(s_fd), 0);
      chk_val("t5_rst_ready", longint'(s_rdy), 1);
      q_s.delete(); q_l.delete();
      m_col = 0; m_row = 0;
      repeat (2) @(negedge clk_fpga);
      reset_fpga = 1'b1;
      got_s.delete(); fd_cnt_s = 0;
      for (int i = 0; i < 12; i++) send(1'b0, 1, 1'b0, 0);
      drain();
      chk_val("t5_count", got_s.size(), 12);
      for (int i = 0; i < 12; i++) chk_val($sformatf("t5_ii_%0d", i), got_at(i), t1_seq[i]);
      chk_val("t5_frame_done", fd_cnt_s, 1);

      // Resync: frame_start on the 7th pixel, then a complete frame from there.
      got_s.delete(); fd_cnt_s = 0;
      for (int i = 0; i < 18; i++) send(1'b0, 1, i == 6, 0);
      drain();
      chk_val("t6_resync_ii", got_at(6), 1);
      chk_val("t6_final_ii", got_at(17), 12);
      chk_val("t6_frame_done", fd_cnt_s, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
